// File: rtl/datapath_pkg.sv
// Shared datapath definitions: result width default and ALU op-select encodings.
// Imported by the host ALU and by the result buffer.
package datapath_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [2:0] ALU_OP_ADD  = 3'd0;
    localparam logic [2:0] ALU_OP_SUB  = 3'd1;
    localparam logic [2:0] ALU_OP_AND  = 3'd2;
    localparam logic [2:0] ALU_OP_OR   = 3'd3;
    localparam logic [2:0] ALU_OP_XOR  = 3'd4;
    localparam logic [2:0] ALU_OP_SHL  = 3'd5;
    localparam logic [2:0] ALU_OP_SHR  = 3'd6;
    localparam logic [2:0] ALU_OP_PASS = 3'd7;

    // Pointer width with the extra wrap bit used by the FIFO full/empty test.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/datapath_result_buffer_if.sv
// Result stream in (valid only, no back-pressure) and buffered stream out (valid/ready).
interface datapath_result_buffer_if
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // master: ALU producer plus downstream consumer; slave: the buffer itself
    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/datapath_result_buffer_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module result_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   widx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   ridx,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[widx] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/datapath_result_buffer.sv
// Buffers the non-stallable ALU result stream in a small FIFO and presents it on valid/ready.
// Words arriving while full (and not freed by a same-cycle pop) are dropped and counted.
module datapath_result_buffer
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int OVF_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    datapath_result_buffer_if.slave  bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [OVF_W-1:0]         overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the slot a full FIFO needs to accept the push.
    assign pop  = !empty && bus.out_ready;
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + {{(OVF_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    result_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .widx  (wr_ptr_q[AW-1:0]),
        .wdata (bus.in_data),
        .ridx  (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    // The array is not reset, so the head is masked while empty.
    assign bus.out_data  = empty ? '0 : rdata;
    assign bus.out_valid = !empty;
    assign level         = wr_ptr_q - rd_ptr_q;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_datapath_result_buffer.sv
// Scoreboard bench for datapath_result_buffer: directed phases plus random traffic,
// checked against a queue-based reference model.
module tb_datapath_result_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int OVF_W  = 8;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic [OVF_W-1:0]       overflow_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_ovf = 0;

    datapath_result_buffer_if #(.DATA_W(DATA_W)) bus ();

    datapath_result_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OVF_W  (OVF_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .level        (level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words with the spec's capacity rule.
    // The monitor removes the head on a handshake before this runs, so
    // "room after pop" decides acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf = 0;
        end else if (bus.in_valid) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(bus.in_data);
            end else if (exp_ovf < OVF_MAX) begin
                exp_ovf++;
            end
        end
    end

    // Monitor: inputs only change just after posedge, so mid-cycle is stable.
    always @(negedge clk) begin
        chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
        chk("level", int'(level), exp_q.size());
        chk("overflow_cnt", int'(overflow_cnt), exp_ovf);
        if (exp_q.size() == 0) begin
            chk("out_data_empty", int'(bus.out_data), 0);
        end else begin
            chk("out_data", int'(bus.out_data), int'(exp_q[0]));
            if (bus.out_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && level != 0; k++) begin
            step();
        end
        chk(name, int'(level), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_data   = 16'h1234;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;

        // Reset held while the ALU keeps pushing
        repeat (3) step();
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_data", int'(bus.out_data), 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_reset_level", int'(level), 0);

        // Single word, held three cycles then consumed
        bus.in_data  = 16'hA5A5;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("single_data", int'(bus.out_data), 16'hA5A5);
        chk("single_level", int'(level), 1);
        repeat (3) step();
        bus.out_ready = 1'b1;
        step();
        chk("single_empty", int'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Fill and drop
        for (int i = 1; i <= 6; i++) begin
            bus.in_data  = DATA_W'(i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_level", int'(level), DEPTH);
        chk("fill_ovf", int'(overflow_cnt), 2);
        drain("fill_drain");

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_data  = DATA_W'(16'h0011 + i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_data   = 16'h00FF;
        bus.out_ready = 1'b1;
        step();
        chk("pushpop_level", int'(level), DEPTH);
        chk("pushpop_ovf", int'(overflow_cnt), 2);
        drain("pushpop_drain");

        // Streaming through the wrap point
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data  = DATA_W'(16'h0100 + i);
            bus.in_valid = 1'b1;
            step();
            chk("stream_level_max", int'(level <= 1), 1);
        end
        drain("stream_drain");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_data   = DATA_W'($urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        drain("random_drain");

        // Saturate the drop counter
        bus.in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 300; i++) begin
            bus.in_data = DATA_W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        chk("sat_ovf", int'(overflow_cnt), OVF_MAX);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pre_reset_level", int'(level), 3);

        // Asynchronous reset away from any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(bus.out_valid), 0);
        chk("async_data", int'(bus.out_data), 0);
        chk("async_level", int'(level), 0);
        chk("async_ovf", int'(overflow_cnt), 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("final_level", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_result_buffer.md
# datapath_result_buffer

Downstream stage of the datapath host ALU. It accepts the ALU's registered 16-bit result stream, which is qualified by a valid strobe and cannot be back-pressured. It holds the results in a small FIFO and presents them on a valid/ready output port for the consuming logic. Because the ALU has no stall input, results that arrive when the buffer is full are dropped and counted in a saturating overflow counter.

## Interface
- DATA_W, 16, width of a result word; must match the ALU result width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- OVF_W, 8, width of the overflow counter.
- clk  input  1  rising-edge clock, shared with the ALU.
- rst_n  input  1  reset; one clock; asynchronous assert, active-low.
- in_data  input  DATA_W  result word from the ALU (result_out).
- in_valid  input  1  result qualifier from the ALU (valid_out); no ready is returned upstream.
- out_data  output  DATA_W  head-of-FIFO word; forced to 0 while empty.
- out_valid  output  1  high whenever the FIFO is non-empty.
- out_ready  input  1  consumer accepts the head word.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_cnt  output  OVF_W  number of dropped words; saturates at all-ones.

## Operation
- pop = out_valid & out_ready. The head advances on the next clock edge.
- push = in_valid & (!full | pop). When full, a pop in the same cycle frees a slot, so the push is accepted.
- drop = in_valid & full & !pop. The word is discarded, and overflow_cnt increments unless it is already at 2^OVF_W-1, where it holds.
- Storage: DEPTH x DATA_W register array. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the extra MSB is a wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Both pointers wrap modulo 2*DEPTH. Array index = pointer low bits.
- level = wr_ptr - rd_ptr, computed modulo 2*DEPTH; it never exceeds DEPTH.
- Push and pop together when non-empty: both pointers advance and level is unchanged.
- Push on empty with out_ready=1: no pop happens (out_valid is 0). The word becomes visible next cycle.
- No combinational path from in_data to out_data. There is no bypass.
- Reset: pointers, level and overflow_cnt clear immediately on rst_n low, independent of clk. The array is not reset.
  - out_valid=0 and out_data=0 during and after reset until the first push.
- Reset mid-operation discards all buffered words and does not count them as drops.

## Timing
- Reset values: out_valid=0, out_data=0, level=0, overflow_cnt=0.
- Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N. The consumer can take it in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- level and overflow_cnt update at the same edge as the push, pop or drop that changes them.
- Reset deassertion must be synchronous to clk; a synchronizer sits outside this block.

## Structure
- Shared package datapath_pkg holds the DATA_W default (16) and the ALU op-select encoding constants; the ALU and this block both import it.
- One sub-module, result_fifo_mem: DEPTH x DATA_W register array with write enable, write index and asynchronous read index.
- Pointer, level and overflow logic stays in the top block.

## Test plan
- Reset: hold rst_n=0 while pushing 0x1234 -> out_valid=0, out_data=0x0000, level=0, overflow_cnt=0. Release -> still empty.
- Single word: in_valid=1 with 0xA5A5 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5, level=1. Hold 3 cycles, then out_ready=1 -> empty after one edge.
- Fill and drop: out_ready=0, push 0x0001..0x0006 on consecutive cycles -> level=4, overflow_cnt=2. Drain yields 0x0001, 0x0002, 0x0003, 0x0004 in order.
- Full with simultaneous push and pop: FIFO full, in_valid=1 with 0x00FF and out_ready=1 -> no drop, level stays 4, 0x00FF is the last word drained.
- Wrap-around: stream 20 words 0x0100+i with out_ready=1 throughout -> output sequence is identical with a 1-cycle lag, level never exceeds 1, overflow_cnt=0.
- Saturation and async reset: force 300 drops -> overflow_cnt=0xFF. Assert rst_n mid-cycle with level=3 -> all outputs clear without a clk edge.
